// File: rtl/xalu_if.sv
// HI/LO unit handshake and result bus between pipeline control and xalu_ctrl.
interface xalu_if;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        xalu_D;
   logic        start;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output op_valid, op, rs_val, rt_val, xalu_D,
      input  start, busy, stall_req, hi, lo
   );

   modport slave (
      input  op_valid, op, rs_val, rt_val, xalu_D,
      output start, busy, stall_req, hi, lo
   );
endinterface

// File: rtl/xalu_ctrl.sv
// HI/LO multiply/divide unit: multi-cycle busy sequencing, HI/LO registers, pipeline stall request.
module xalu_ctrl #(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input  logic  clk,
   input  logic  reset,
   xalu_if.slave xif
);
   localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MADD  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             start_c;

   logic [63:0]      prod_s;
   logic [63:0]      prod_u;
   logic [63:0]      madd_sum;
   logic [31:0]      quot_s, rem_s;
   logic [31:0]      quot_u, rem_u;

   // Arithmetic on the latched operands; only consumed on the completing edge.
   always_comb begin
      prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u   = {32'd0, a_q} * {32'd0, b_q};
      madd_sum = {hi_q, lo_q} + prod_s;
      quot_u   = a_q / b_q;
      rem_u    = a_q % b_q;
      if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
         // Overflowing signed quotient wraps to the dividend, remainder zero.
         quot_s = 32'h8000_0000;
         rem_s  = 32'd0;
      end else begin
         quot_s = 32'($signed(a_q) / $signed(b_q));
         rem_s  = 32'($signed(a_q) % $signed(b_q));
      end
   end

   // Next-state, operand latch, counter and HI/LO update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      start_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (xif.op_valid && !reset) begin
               case (xif.op)
                  OP_MULT, OP_MULTU, OP_MADD, OP_DIV, OP_DIVU: begin
                     start_c = 1'b1;
                     op_d    = xif.op;
                     a_d     = xif.rs_val;
                     b_d     = xif.rt_val;
                     cnt_d   = (xif.op == OP_DIV || xif.op == OP_DIVU) ?
                               CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
                     state_d = RUN;
                  end
                  OP_MTHI: hi_d = xif.rs_val;
                  OP_MTLO: lo_d = xif.rs_val;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = IDLE;
               case (op_q)
                  OP_MULT:  {hi_d, lo_d} = prod_s;
                  OP_MULTU: {hi_d, lo_d} = prod_u;
                  OP_MADD:  {hi_d, lo_d} = madd_sum;
                  OP_DIV: begin
                     if (b_q != 32'd0) begin
                        lo_d = quot_s;
                        hi_d = rem_s;
                     end
                  end
                  OP_DIVU: begin
                     if (b_q != 32'd0) begin
                        lo_d = quot_u;
                        hi_d = rem_u;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Output drive: busy straight from the state flop, start/stall combinational.
   always_comb begin
      xif.start     = start_c;
      xif.busy      = (state_q == RUN);
      xif.stall_req = xif.xalu_D & (start_c | (state_q == RUN));
      xif.hi        = hi_q;
      xif.lo        = lo_q;
   end
endmodule

// File: tb/tb_xalu_ctrl.sv
// Self-checking bench for xalu_ctrl: per-cycle model comparison plus directed literal checks.
module tb_xalu_ctrl;
   localparam int unsigned MULT_CYC = 5;
   localparam int unsigned DIV_CYC  = 10;

   logic clk;
   logic reset;
   xalu_if xif ();

   xalu_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
      .clk   (clk),
      .reset (reset),
      .xif   (xif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: remaining busy cycles plus architectural HI/LO.
   int          m_left = 0;
   logic [2:0]  m_op   = '0;
   logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;
   longint      sp, sq, sr;
   logic [63:0] up;

   always @(posedge clk) begin
      if (reset) begin
         m_left = 0; m_op = '0; m_a = '0; m_b = '0; m_hi = '0; m_lo = '0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            case (m_op)
               3'd1: begin sp = longint'($signed(m_a)) * longint'($signed(m_b)); {m_hi, m_lo} = 64'(sp); end
               3'd2: begin up = 64'(m_a) * 64'(m_b); {m_hi, m_lo} = up; end
               3'd5: begin sp = longint'($signed(m_a)) * longint'($signed(m_b)); {m_hi, m_lo} = {m_hi, m_lo} + 64'(sp); end
               3'd3: if (m_b != 0) begin
                  sq = longint'($signed(m_a)) / longint'($signed(m_b));
                  sr = longint'($signed(m_a)) % longint'($signed(m_b));
                  m_lo = sq[31:0]; m_hi = sr[31:0];
               end
               3'd4: if (m_b != 0) begin m_lo = m_a / m_b; m_hi = m_a % m_b; end
               default: ;
            endcase
         end
      end else if (xif.op_valid) begin
         if (xif.op >= 3'd1 && xif.op <= 3'd5) begin
            m_op = xif.op; m_a = xif.rs_val; m_b = xif.rt_val;
            m_left = (xif.op == 3'd3 || xif.op == 3'd4) ? DIV_CYC : MULT_CYC;
         end else if (xif.op == 3'd6) m_hi = xif.rs_val;
         else if (xif.op == 3'd7) m_lo = xif.rs_val;
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      logic e_start, e_busy;
      if (chk_en) begin
         e_busy  = (m_left > 0);
         e_start = !reset && xif.op_valid && !e_busy && xif.op >= 3'd1 && xif.op <= 3'd5;
         check("cyc_start", 32'(xif.start), 32'(e_start));
         check("cyc_busy",  32'(xif.busy),  32'(e_busy));
         check("cyc_stall", 32'(xif.stall_req), 32'(xif.xalu_D && (e_start || e_busy)));
         check("cyc_hi", xif.hi, m_hi);
         check("cyc_lo", xif.lo, m_lo);
      end
   end

   task automatic align();
      @(posedge clk); #1;
   endtask

   // Issue one op from posedge+1; ends at the negedge where busy is low again.
   task automatic op_task(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic xd, input bit inject, input string tag,
                          output int nbusy, output int nstall);
      xif.op_valid = 1'b1; xif.op = op; xif.rs_val = rs; xif.rt_val = rt; xif.xalu_D = xd;
      nbusy = 0; nstall = 0;
      @(negedge clk);
      check({tag, "_start"}, 32'(xif.start), 32'(op >= 3'd1 && op <= 3'd5));
      if (xif.stall_req) nstall++;
      align();
      xif.op_valid = inject; xif.op = 3'd6; xif.rs_val = 32'hDEAD_BEEF;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!xif.busy) break;
         nbusy++;
         if (xif.stall_req) nstall++;
         if (i == 39) check({tag, "_busy_timeout"}, 32'd1, 32'd0);
         align();
         if (nbusy >= 2) xif.op_valid = 1'b0;
      end
      xif.op_valid = 1'b0;
   endtask

   int nb, ns;

   initial begin
      reset = 1'b1;
      xif.op_valid = 1'b0; xif.op = '0; xif.rs_val = '0; xif.rt_val = '0; xif.xalu_D = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      align();
      check("rst_busy", 32'(xif.busy), 32'd0);
      check("rst_hi", xif.hi, 32'd0);
      check("rst_lo", xif.lo, 32'd0);
      // Reset released in the same cycle the first op is presented.
      reset = 1'b0;
      op_task(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, "mult", nb, ns);
      check("mult_nbusy", 32'(nb), 32'd5);
      check("mult_hi", xif.hi, 32'hFFFF_FFFF);
      check("mult_lo", xif.lo, 32'hFFFF_FFFA);

      align();
      op_task(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, "multu", nb, ns);
      check("multu_nbusy", 32'(nb), 32'd5);
      check("multu_hi", xif.hi, 32'h0000_0001);
      check("multu_lo", xif.lo, 32'hFFFF_FFFE);

      align();
      op_task(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div", nb, ns);
      check("div_nbusy", 32'(nb), 32'd10);
      check("div_nstall", 32'(ns), 32'd11);
      check("div_stall_fall", 32'(xif.stall_req), 32'd0);
      check("div_lo", xif.lo, 32'hFFFF_FFFD);
      check("div_hi", xif.hi, 32'hFFFF_FFFF);

      align();
      op_task(3'd4, 32'd7, 32'd0, 1'b0, 1'b0, "divu0", nb, ns);
      check("divu0_nbusy", 32'(nb), 32'd10);
      check("divu0_hi", xif.hi, 32'hFFFF_FFFF);
      check("divu0_lo", xif.lo, 32'hFFFF_FFFD);

      align();
      op_task(3'd4, 32'd100, 32'd7, 1'b0, 1'b0, "divu", nb, ns);
      check("divu_lo", xif.lo, 32'd14);
      check("divu_hi", xif.hi, 32'd2);

      align();
      op_task(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "divovf", nb, ns);
      check("divovf_lo", xif.lo, 32'h8000_0000);
      check("divovf_hi", xif.hi, 32'h0000_0000);

      align();
      op_task(3'd0, 32'h1234_5678, 32'd9, 1'b1, 1'b0, "nop", nb, ns);
      check("nop_nbusy", 32'(nb), 32'd0);
      check("nop_lo", xif.lo, 32'h8000_0000);

      align();
      op_task(3'd6, 32'h1, 32'd0, 1'b1, 1'b0, "mthi", nb, ns);
      check("mthi_nstall", 32'(ns), 32'd0);
      check("mthi_hi", xif.hi, 32'h1);
      align();
      op_task(3'd7, 32'h2, 32'd0, 1'b0, 1'b0, "mtlo", nb, ns);
      check("mtlo_lo", xif.lo, 32'h2);
      align();
      op_task(3'd5, 32'd3, 32'd4, 1'b0, 1'b1, "madd", nb, ns);
      check("madd_nbusy", 32'(nb), 32'd5);
      check("madd_hi", xif.hi, 32'h1);
      check("madd_lo", xif.lo, 32'hE);

      align();
      op_task(3'd6, 32'h0, 32'd0, 1'b0, 1'b0, "mthi0", nb, ns);
      align();
      op_task(3'd7, 32'h5, 32'd0, 1'b0, 1'b0, "mtlo5", nb, ns);
      align();
      op_task(3'd5, 32'hFFFF_FFFF, 32'd10, 1'b0, 1'b0, "maddneg", nb, ns);
      check("maddneg_hi", xif.hi, 32'hFFFF_FFFF);
      check("maddneg_lo", xif.lo, 32'hFFFF_FFFB);

      // Reset in the third busy cycle of a mult aborts it.
      align();
      xif.op_valid = 1'b1; xif.op = 3'd1; xif.rs_val = 32'd5; xif.rt_val = 32'd7;
      align();
      xif.op_valid = 1'b0;
      align();
      align();
      reset = 1'b1;
      align();
      reset = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(xif.busy), 32'd0);
      check("abort_hi", xif.hi, 32'd0);
      check("abort_lo", xif.lo, 32'd0);
      repeat (8) align();
      check("abort_nowrite_hi", xif.hi, 32'd0);
      check("abort_nowrite_lo", xif.lo, 32'd0);

      repeat (2) align();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/xalu_ctrl.md
XALU_CTRL -- requirements
Module: xalu_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, busy cycles for mult/multu/madd.
REQ-002 Parameter DIV_CYC, default 10, busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op_valid  input  1  E-stage instruction is an HI/LO-unit op, qualified this cycle.
REQ-006 op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 mthi, 7 mtlo.
REQ-007 rs_val  input  32  forwarded RS operand.
REQ-008 rt_val  input  32  forwarded RT operand.
REQ-009 xalu_D  input  1  D-stage instruction is an HI/LO-unit type (mult..madd, mfhi, mflo, mthi, mtlo).
REQ-010 start  output  1  combinational; multi-cycle op accepted this cycle.
REQ-011 busy  output  1  registered; multi-cycle op in progress.
REQ-012 stall_req  output  1  combinational; request to freeze PC/D stage and bubble E.
REQ-013 hi  output  32  HI register, read by mfhi.
REQ-014 lo  output  32  LO register, read by mflo.

Function
REQ-015 FSM states: IDLE, RUN; reset -> IDLE.
REQ-016 Accept only when state = IDLE and op_valid = 1; op_valid in RUN is ignored, with no state or HI/LO change.
REQ-017 start = op_valid & IDLE & op in {1,2,3,4,5}; op 0 never starts or writes.
REQ-018 On start: latch op, rs_val, rt_val; load down-counter with MULT_CYC (op 1,2,5) or DIV_CYC (op 3,4); go to RUN; busy = 1 from next cycle.
REQ-019 RUN: counter decrements each cycle; at the edge where the counter goes 1 -> 0, write HI/LO with the result, return to IDLE, busy = 0 from next cycle.
REQ-020 busy is high for exactly MULT_CYC or DIV_CYC consecutive cycles per op.
REQ-021 HI/LO are unchanged throughout RUN; new values are visible in the first cycle busy = 0.
REQ-022 mult: {hi,lo} = signed 32x32 -> 64-bit product.
REQ-023 multu: {hi,lo} = unsigned 32x32 -> 64-bit product.
REQ-024 madd: {hi,lo} = {hi,lo} + signed product, modulo 2^64, using HI/LO values at completion.
REQ-025 div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-026 divu: lo = unsigned quotient; hi = unsigned remainder.
REQ-027 div/divu with rt_val = 0: full DIV_CYC busy period; HI and LO unchanged.
REQ-028 div with 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-029 mthi (op 6): hi <= rs_val at next edge when IDLE; single-cycle; no busy.
REQ-030 mtlo (op 7): lo <= rs_val at next edge when IDLE; single-cycle; no busy.
REQ-031 stall_req = xalu_D & (start | busy).
REQ-032 stall_req = 0 in the cycle busy falls; mfhi/mflo in D then reads the new result.

Reset
REQ-033 reset = 1 at an edge: state = IDLE, counter = 0, busy = 0, hi = 0, lo = 0, latched operands = 0.
REQ-034 Reset during RUN aborts the op; no HI/LO write occurs; start is suppressed while reset = 1.
REQ-035 After reset deasserts, the first op_valid is accepted in the same cycle.

Verification
REQ-036 mult rs=0xFFFFFFFE (-2), rt=3 -> start 1 cycle, busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-037 multu rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-038 div rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 -> hi/lo unchanged after 10 cycles.
REQ-039 mthi 0x1 then mtlo 0x2, then madd rs=3, rt=4 -> hi=0x1, lo=0xE; second op_valid during busy -> ignored.
REQ-040 xalu_D=1 held during a div -> stall_req high on the start cycle plus 10 busy cycles (11 total), low when busy falls.
REQ-041 reset pulsed in the 3rd busy cycle of mult -> busy=0, hi=lo=0 next cycle, no later write.
